biriscv_issue_sched: RTL and testbench
======================================

BIRISCV_ISSUE_SCHED -- requirements
Module: biriscv_issue_sched

Interface
REQ-001 SHALL have parameter DUAL_ISSUE, default 1, meaning slot1 may issue in the same cycle as slot0.
REQ-002 SHALL have parameter VEC_CREDITS, default 4, meaning vector-unit queue entries (1..15).
REQ-003 SHALL have parameter CSR_DRAIN_CYCLES, default 3, meaning post-CSR issue blackout (1..7).
REQ-004 SHALL have port clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-006 SHALL have ports slotN_valid_i  in  1  decoded instruction present, N=0 (older) and N=1.
REQ-007 SHALL have ports slotN_instr_i  in  32  raw opcode; rd=[11:7], rs1=[19:15], rs2=[24:20].
REQ-008 SHALL have ports slotN_{lsu,mul,div,csr,branch,vector,rd_valid,invalid}_i  in  1 each  decode class flags.
REQ-009 SHALL have ports slotN_fault_i  in  1  fetch or page fault on the slot.
REQ-010 SHALL have port stall_i  in  1  downstream pipeline cannot accept issue.
REQ-011 SHALL have port branch_request_i  in  1  pipeline flush.
REQ-012 SHALL have port div_done_i  in  1  divider result written back.
REQ-013 SHALL have port vec_done_i  in  1  one vector-queue entry retired.
REQ-014 SHALL have ports slotN_accept_o  out  1  slot issued this cycle (pops the fetch FIFO slot).
REQ-015 SHALL have port vec_credits_o  out  4  current free vector credits.
REQ-016 SHALL have port busy_o  out  1  state is not RUN.

Function
REQ-017 SHALL implement states RUN, DIV_WAIT, CSR_DRAIN; issue is permitted only in RUN.
REQ-018 SHALL force both accepts to 0 while stall_i, branch_request_i or rst_i is high.
REQ-019 SHALL issue slot0 in RUN when slot0_valid_i is high, subject to REQ-022 and REQ-023.
REQ-020 SHALL treat slot1 as oldest when slot0_valid_i is low, issuing it under slot0 rules.
REQ-021 SHALL issue slot1 alongside slot0 only if DUAL_ISSUE=1 and slot0 issues this cycle.
REQ-022 SHALL block same-cycle slot1 issue when any of: both lsu; both mul; either div, csr, vector, invalid or fault; slot0 branch and slot1 branch; slot0 rd_valid with rd!=0 and rd equal to slot1 rs1, rs2 or (if slot1 rd_valid) rd.
REQ-023 SHALL block issue of any vector-flagged slot while vec_credits_o==0.
REQ-024 SHALL decrement credits on vector issue and increment on vec_done_i; both in one cycle leaves the count unchanged.
REQ-025 SHALL ignore vec_done_i when credits==VEC_CREDITS (saturate, no wrap).
REQ-026 SHALL move RUN->DIV_WAIT on the cycle a div slot is accepted, and DIV_WAIT->RUN on the cycle after div_done_i.
REQ-027 SHALL move RUN->CSR_DRAIN on CSR accept, load a counter with CSR_DRAIN_CYCLES, and return to RUN when it reaches 0.
REQ-028 SHALL ignore div_done_i outside DIV_WAIT.
REQ-029 SHALL, on branch_request_i, return CSR_DRAIN to RUN next cycle; DIV_WAIT and credits SHALL be unaffected.
REQ-030 SHALL generate accepts combinationally from inputs and registered state (zero-cycle issue latency).

Reset
REQ-031 SHALL reset to state RUN, drain counter 0, vec_credits_o=VEC_CREDITS, busy_o=0, accepts 0.
REQ-032 SHALL make reset asserted mid-DIV_WAIT or mid-CSR_DRAIN abandon the wait, with RUN on the next cycle.

Structure
REQ-033 SHALL place state encodings and register-field bit positions in the shared core package.
REQ-034 SHALL contain one sub-module, biriscv_issue_hazard, holding the combinational REQ-022 pair check.

Verification
REQ-035 SHALL test: slot0 add x5, slot1 add x6,x5,x1, both valid -> slot0_accept=1, slot1_accept=0; next cycle slot1 accepts.
REQ-036 SHALL test: slot0 lw, slot1 mul, no deps -> both accepts=1 in the same cycle; with DUAL_ISSUE=0 -> slot0 only.
REQ-037 SHALL test: div issued, div_done_i 5 cycles later -> busy_o=1 for 6 cycles, no accepts until RUN.
REQ-038 SHALL test: VEC_CREDITS=2, three vector ops, no vec_done_i -> third blocked, vec_credits_o=0; vec_done_i -> third issues the following cycle.
REQ-039 SHALL test: CSR write then add -> add accepted exactly CSR_DRAIN_CYCLES+1 cycles later.
REQ-040 SHALL test: rst_i pulsed during DIV_WAIT -> RUN next cycle, credits=VEC_CREDITS, accepts resume.

Source files
------------

// File: rtl/biriscv_issue_sched_pkg.sv
// Shared definitions for the issue scheduler: state encodings and the
// instruction register-field positions used by the pair hazard check.
package biriscv_issue_sched_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_DIV_WAIT  = 2'd1,
    ST_CSR_DRAIN = 2'd2
  } sched_state_t;

  localparam int REG_W   = 5;
  localparam int RD_LSB  = 7;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;

  function automatic logic [REG_W-1:0] rd_of(input logic [31:0] instr);
    return instr[RD_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rs1_of(input logic [31:0] instr);
    return instr[RS1_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] rs2_of(input logic [31:0] instr);
    return instr[RS2_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/biriscv_issue_hazard.sv
// Combinational check deciding whether the younger slot may issue in the
// same cycle as the older one (structural, serialising and RAW/WAW rules).
module biriscv_issue_hazard
  import biriscv_issue_sched_pkg::*;
(
  input  logic [REG_W-1:0] slot0_rd_i,
  input  logic [REG_W-1:0] slot1_rd_i,
  input  logic [REG_W-1:0] slot1_rs1_i,
  input  logic [REG_W-1:0] slot1_rs2_i,
  input  logic             slot0_lsu_i,
  input  logic             slot0_mul_i,
  input  logic             slot0_div_i,
  input  logic             slot0_csr_i,
  input  logic             slot0_branch_i,
  input  logic             slot0_vector_i,
  input  logic             slot0_rd_valid_i,
  input  logic             slot0_invalid_i,
  input  logic             slot0_fault_i,
  input  logic             slot1_lsu_i,
  input  logic             slot1_mul_i,
  input  logic             slot1_div_i,
  input  logic             slot1_csr_i,
  input  logic             slot1_branch_i,
  input  logic             slot1_vector_i,
  input  logic             slot1_rd_valid_i,
  input  logic             slot1_invalid_i,
  input  logic             slot1_fault_i,
  output logic             pair_block_o
);

  logic structural;
  logic serialising;
  logic reg_dep;

  always_comb begin
    structural  = (slot0_lsu_i & slot1_lsu_i) | (slot0_mul_i & slot1_mul_i) |
                  (slot0_branch_i & slot1_branch_i);
    // Any of these must issue alone so the pipeline sees them in isolation
    serialising = slot0_div_i | slot1_div_i | slot0_csr_i | slot1_csr_i |
                  slot0_vector_i | slot1_vector_i | slot0_invalid_i |
                  slot1_invalid_i | slot0_fault_i | slot1_fault_i;
    reg_dep     = slot0_rd_valid_i && (slot0_rd_i != '0) &&
                  ((slot0_rd_i == slot1_rs1_i) || (slot0_rd_i == slot1_rs2_i) ||
                   (slot1_rd_valid_i && (slot0_rd_i == slot1_rd_i)));
    pair_block_o = structural | serialising | reg_dep;
  end

endmodule

// File: rtl/biriscv_issue_sched.sv
// Dual-slot issue scheduler: zero-latency accept generation, divider and
// CSR issue blackouts, and vector-queue credit accounting.
module biriscv_issue_sched
  import biriscv_issue_sched_pkg::*;
#(
  parameter int DUAL_ISSUE       = 1,
  parameter int VEC_CREDITS      = 4,
  parameter int CSR_DRAIN_CYCLES = 3
)
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        slot0_valid_i,
  input  logic [31:0] slot0_instr_i,
  input  logic        slot0_lsu_i,
  input  logic        slot0_mul_i,
  input  logic        slot0_div_i,
  input  logic        slot0_csr_i,
  input  logic        slot0_branch_i,
  input  logic        slot0_vector_i,
  input  logic        slot0_rd_valid_i,
  input  logic        slot0_invalid_i,
  input  logic        slot0_fault_i,
  input  logic        slot1_valid_i,
  input  logic [31:0] slot1_instr_i,
  input  logic        slot1_lsu_i,
  input  logic        slot1_mul_i,
  input  logic        slot1_div_i,
  input  logic        slot1_csr_i,
  input  logic        slot1_branch_i,
  input  logic        slot1_vector_i,
  input  logic        slot1_rd_valid_i,
  input  logic        slot1_invalid_i,
  input  logic        slot1_fault_i,
  input  logic        stall_i,
  input  logic        branch_request_i,
  input  logic        div_done_i,
  input  logic        vec_done_i,
  output logic        slot0_accept_o,
  output logic        slot1_accept_o,
  output logic [3:0]  vec_credits_o,
  output logic        busy_o
);

  localparam logic [3:0] VEC_MAX    = 4'(VEC_CREDITS);
  localparam logic [2:0] DRAIN_LOAD = 3'(CSR_DRAIN_CYCLES);

  sched_state_t state_q, state_d;
  logic [2:0]   drain_q, drain_d;
  logic [3:0]   credits_q, credits_d;
  logic         div_done_q, div_done_d;
  logic         pair_block, issue_ok, vec0_ok, vec1_ok;
  logic         div_issue, csr_issue, vec_issue, credit_ret;
  logic         unused_instr_bits;

  assign unused_instr_bits = ^{slot0_instr_i[31:12], slot0_instr_i[6:0],
                               slot1_instr_i[31:25], slot1_instr_i[14:12], slot1_instr_i[6:0]};

  biriscv_issue_hazard u_hazard (
    .slot0_rd_i      (rd_of(slot0_instr_i)),
    .slot1_rd_i      (rd_of(slot1_instr_i)),
    .slot1_rs1_i     (rs1_of(slot1_instr_i)),
    .slot1_rs2_i     (rs2_of(slot1_instr_i)),
    .slot0_lsu_i     (slot0_lsu_i),
    .slot0_mul_i     (slot0_mul_i),
    .slot0_div_i     (slot0_div_i),
    .slot0_csr_i     (slot0_csr_i),
    .slot0_branch_i  (slot0_branch_i),
    .slot0_vector_i  (slot0_vector_i),
    .slot0_rd_valid_i(slot0_rd_valid_i),
    .slot0_invalid_i (slot0_invalid_i),
    .slot0_fault_i   (slot0_fault_i),
    .slot1_lsu_i     (slot1_lsu_i),
    .slot1_mul_i     (slot1_mul_i),
    .slot1_div_i     (slot1_div_i),
    .slot1_csr_i     (slot1_csr_i),
    .slot1_branch_i  (slot1_branch_i),
    .slot1_vector_i  (slot1_vector_i),
    .slot1_rd_valid_i(slot1_rd_valid_i),
    .slot1_invalid_i (slot1_invalid_i),
    .slot1_fault_i   (slot1_fault_i),
    .pair_block_o    (pair_block)
  );

  // When slot0 is empty, slot1 is the oldest and issues under slot0's rules
  always_comb begin
    issue_ok       = (state_q == ST_RUN) && !stall_i && !branch_request_i && !rst_i;
    vec0_ok        = !slot0_vector_i || (credits_q != '0);
    vec1_ok        = !slot1_vector_i || (credits_q != '0);
    slot0_accept_o = issue_ok && slot0_valid_i && vec0_ok;
    if (slot0_valid_i)
      slot1_accept_o = (DUAL_ISSUE != 0) && slot0_accept_o && slot1_valid_i &&
                       !pair_block && vec1_ok;
    else
      slot1_accept_o = issue_ok && slot1_valid_i && vec1_ok;
    div_issue  = (slot0_accept_o & slot0_div_i) | (slot1_accept_o & slot1_div_i);
    csr_issue  = (slot0_accept_o & slot0_csr_i) | (slot1_accept_o & slot1_csr_i);
    vec_issue  = (slot0_accept_o & slot0_vector_i) | (slot1_accept_o & slot1_vector_i);
    credit_ret = vec_done_i && (credits_q != VEC_MAX);
  end

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    div_done_d = div_done_q;
    credits_d  = credits_q - {3'b000, vec_issue} + {3'b000, credit_ret};
    case (state_q)
      ST_RUN: begin
        div_done_d = 1'b0;
        if (div_issue) begin
          state_d = ST_DIV_WAIT;
        end else if (csr_issue) begin
          state_d = ST_CSR_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      // Writeback seen last cycle releases the wait one cycle later
      ST_DIV_WAIT: begin
        if (div_done_q) begin
          state_d    = ST_RUN;
          div_done_d = 1'b0;
        end else if (div_done_i) begin
          div_done_d = 1'b1;
        end
      end
      ST_CSR_DRAIN: begin
        if (branch_request_i || (drain_q <= 3'd1)) begin
          state_d = ST_RUN;
          drain_d = '0;
        end else begin
          drain_d = drain_q - 3'd1;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_RUN;
      drain_q    <= '0;
      credits_q  <= VEC_MAX;
      div_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      credits_q  <= credits_d;
      div_done_q <= div_done_d;
    end
  end

  assign vec_credits_o = credits_q;
  assign busy_o        = (state_q != ST_RUN);

endmodule

// File: tb/tb_biriscv_issue_sched.sv
// Scoreboard bench: two scheduler instances (dual/single issue, different
// credit and drain sizes) driven identically and checked against a rule model.
module tb_biriscv_issue_sched;

  localparam int S_RUN = 0;
  localparam int S_DIV = 1;
  localparam int S_CSR = 2;
  localparam int P_DI [2] = '{1, 0};
  localparam int P_VC [2] = '{2, 4};
  localparam int P_CD [2] = '{3, 5};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  v = '0, lsu = '0, mul = '0, dv = '0, csr = '0, brn = '0;
  logic [1:0]  vec = '0, rdv = '0, inv = '0, flt = '0;
  logic [31:0] ins [2] = '{32'h0, 32'h0};
  logic        stall = 1'b0, brq = 1'b0, ddone = 1'b0, vdone = 1'b0;

  logic [1:0]  acc0, acc1, busy;
  logic [3:0]  cred0, cred1;

  typedef struct {
    string      tag;
    logic [6:0] exp0;
    logic [6:0] exp1;
  } exp_t;
  exp_t sb_q[$];

  int checks = 0;
  int failures = 0;
  int mcyc = 0;
  int m_state [2];
  int m_cred [2];
  int m_rel [2];
  int m_end [2];

  always #5 clk = ~clk;

  biriscv_issue_sched #(.DUAL_ISSUE(1), .VEC_CREDITS(2), .CSR_DRAIN_CYCLES(3)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .slot0_valid_i(v[0]), .slot0_instr_i(ins[0]), .slot0_lsu_i(lsu[0]), .slot0_mul_i(mul[0]),
    .slot0_div_i(dv[0]), .slot0_csr_i(csr[0]), .slot0_branch_i(brn[0]), .slot0_vector_i(vec[0]),
    .slot0_rd_valid_i(rdv[0]), .slot0_invalid_i(inv[0]), .slot0_fault_i(flt[0]),
    .slot1_valid_i(v[1]), .slot1_instr_i(ins[1]), .slot1_lsu_i(lsu[1]), .slot1_mul_i(mul[1]),
    .slot1_div_i(dv[1]), .slot1_csr_i(csr[1]), .slot1_branch_i(brn[1]), .slot1_vector_i(vec[1]),
    .slot1_rd_valid_i(rdv[1]), .slot1_invalid_i(inv[1]), .slot1_fault_i(flt[1]),
    .stall_i(stall), .branch_request_i(brq), .div_done_i(ddone), .vec_done_i(vdone),
    .slot0_accept_o(acc0[0]), .slot1_accept_o(acc1[0]), .vec_credits_o(cred0), .busy_o(busy[0])
  );

  biriscv_issue_sched #(.DUAL_ISSUE(0), .VEC_CREDITS(4), .CSR_DRAIN_CYCLES(5)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .slot0_valid_i(v[0]), .slot0_instr_i(ins[0]), .slot0_lsu_i(lsu[0]), .slot0_mul_i(mul[0]),
    .slot0_div_i(dv[0]), .slot0_csr_i(csr[0]), .slot0_branch_i(brn[0]), .slot0_vector_i(vec[0]),
    .slot0_rd_valid_i(rdv[0]), .slot0_invalid_i(inv[0]), .slot0_fault_i(flt[0]),
    .slot1_valid_i(v[1]), .slot1_instr_i(ins[1]), .slot1_lsu_i(lsu[1]), .slot1_mul_i(mul[1]),
    .slot1_div_i(dv[1]), .slot1_csr_i(csr[1]), .slot1_branch_i(brn[1]), .slot1_vector_i(vec[1]),
    .slot1_rd_valid_i(rdv[1]), .slot1_invalid_i(inv[1]), .slot1_fault_i(flt[1]),
    .stall_i(stall), .branch_request_i(brq), .div_done_i(ddone), .vec_done_i(vdone),
    .slot0_accept_o(acc0[1]), .slot1_accept_o(acc1[1]), .vec_credits_o(cred1), .busy_o(busy[1])
  );

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    return 32'((rs2 << 20) | (rs1 << 15) | (rd << 7) | 'h33);
  endfunction

  // Same-cycle pairing rules, computed directly from the opcode fields
  function automatic bit conflict();
    int rd0  = int'((ins[0] >> 7) & 32'd31);
    int rd1  = int'((ins[1] >> 7) & 32'd31);
    int rs11 = int'((ins[1] >> 15) & 32'd31);
    int rs21 = int'((ins[1] >> 20) & 32'd31);
    if (lsu[0] && lsu[1]) return 1;
    if (mul[0] && mul[1]) return 1;
    if (brn[0] && brn[1]) return 1;
    if ((dv != 0) || (csr != 0) || (vec != 0) || (inv != 0) || (flt != 0)) return 1;
    if (rdv[0] && rd0 != 0 && (rd0 == rs11 || rd0 == rs21 || (rdv[1] && rd0 == rd1))) return 1;
    return 0;
  endfunction

  task automatic model_reset(input int k);
    m_state[k] = S_RUN;
    m_cred[k]  = P_VC[k];
    m_rel[k]   = -1;
    m_end[k]   = 0;
  endtask

  task automatic model_step(input int k, output logic [6:0] ex);
    bit a [2];
    int issued = 0;
    int nvec = 0;
    bit took_div = 0, took_csr = 0;
    a[0] = 0;
    a[1] = 0;
    if (m_state[k] == S_RUN && !stall && !brq && !rst) begin
      for (int n = 0; n < 2; n++) begin
        if (!v[n]) continue;
        if (issued == 1 && (P_DI[k] == 0 || conflict())) break;
        if (vec[n] && m_cred[k] == 0) break;
        a[n] = 1;
        issued++;
        if (vec[n]) nvec++;
        if (dv[n]) took_div = 1;
        if (csr[n]) took_csr = 1;
      end
    end
    ex = {a[0], a[1], 4'(m_cred[k]), (m_state[k] != S_RUN)};
    if (rst) begin
      model_reset(k);
    end else begin
      m_cred[k] = m_cred[k] - nvec + ((vdone && m_cred[k] < P_VC[k]) ? 1 : 0);
      case (m_state[k])
        S_RUN: begin
          if (took_div) begin
            m_state[k] = S_DIV;
            m_rel[k] = -1;
          end else if (took_csr) begin
            m_state[k] = S_CSR;
            m_end[k] = mcyc + P_CD[k];
          end
        end
        S_DIV: begin
          if (m_rel[k] >= 0 && mcyc + 1 >= m_rel[k]) m_state[k] = S_RUN;
          else if (m_rel[k] < 0 && ddone) m_rel[k] = mcyc + 2;
        end
        default: if (brq || mcyc + 1 > m_end[k]) m_state[k] = S_RUN;
      endcase
    end
  endtask

  // Record the expectation for the inputs now on the bus, then advance a cycle
  task automatic step(input string tag);
    exp_t e;
    e.tag = tag;
    model_step(0, e.exp0);
    model_step(1, e.exp1);
    sb_q.push_back(e);
    mcyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    v = '0; lsu = '0; mul = '0; dv = '0; csr = '0; brn = '0;
    vec = '0; rdv = '0; inv = '0; flt = '0;
    stall = 0; brq = 0; ddone = 0; vdone = 0; rst = 0;
  endtask

  task automatic set_slot(input int n, input int rd, input int rs1, input int rs2, input string cls);
    v[n]   = 1'b1;
    ins[n] = mk(rd, rs1, rs2);
    lsu[n] = (cls == "lsu");
    mul[n] = (cls == "mul");
    dv[n]  = (cls == "div");
    csr[n] = (cls == "csr");
    brn[n] = (cls == "br");
    vec[n] = (cls == "vec");
    inv[n] = 1'b0;
    flt[n] = 1'b0;
    rdv[n] = (cls != "br") && (cls != "vec");
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    step("reset");
    rst = 0;
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      logic [6:0] got0, got1;
      e = sb_q.pop_front();
      got0 = {acc0[0], acc1[0], cred0, busy[0]};
      got1 = {acc1[1] ? 1'b0 : acc0[1], acc1[1], cred1, busy[1]};
      got1[6] = acc0[1];
      checks++;
      if (got0 !== e.exp0) begin
        failures++;
        $display("FAIL %s dut0 {acc0,acc1,credits,busy} got=%b want=%b t=%0t", e.tag, got0, e.exp0, $time);
      end
      checks++;
      if (got1 !== e.exp1) begin
        failures++;
        $display("FAIL %s dut1 {acc0,acc1,credits,busy} got=%b want=%b t=%0t", e.tag, got1, e.exp1, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog bench did not finish got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    do_reset();
    step("reset_hold");

    clear_inputs();
    set_slot(0, 5, 1, 2, "alu");
    set_slot(1, 6, 5, 1, "alu");
    step("raw_pair");
    v[0] = 0;
    step("raw_next");

    clear_inputs();
    set_slot(0, 7, 2, 0, "lsu");
    set_slot(1, 8, 3, 4, "mul");
    step("lw_mul");

    clear_inputs();
    set_slot(0, 9, 1, 2, "div");
    step("div_issue");
    for (int i = 1; i <= 8; i++) begin
      clear_inputs();
      set_slot(0, 10, 1, 2, "alu");
      ddone = (i == 5);
      step("div_wait");
    end

    do_reset();
    for (int i = 0; i < 6; i++) begin
      clear_inputs();
      set_slot(0, 0, 1, 2, "vec");
      vdone = (i == 4);
      step(i < 2 ? "vec_issue" : (i < 4 ? "vec_blocked" : (i == 4 ? "vec_done" : "vec_resume")));
    end

    do_reset();
    clear_inputs();
    set_slot(0, 11, 1, 0, "csr");
    step("csr_write");
    for (int i = 0; i < 8; i++) begin
      clear_inputs();
      set_slot(0, 12, 3, 4, "alu");
      step("csr_drain");
    end

    do_reset();
    clear_inputs();
    set_slot(0, 0, 1, 2, "vec");
    step("rst_vec");
    clear_inputs();
    set_slot(0, 13, 1, 2, "div");
    step("rst_div_issue");
    for (int i = 0; i < 5; i++) begin
      clear_inputs();
      set_slot(0, 14, 1, 2, "alu");
      rst = (i == 2);
      step(i < 2 ? "div_hold" : (i == 2 ? "rst_in_div" : "rst_resume"));
    end

    do_reset();
    for (int c = 0; c < 2500; c++) begin
      for (int n = 0; n < 2; n++) begin
        v[n]   = ($urandom_range(0, 9) < 8);
        ins[n] = mk($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
        lsu[n] = ($urandom_range(0, 99) < 25);
        mul[n] = ($urandom_range(0, 99) < 20);
        dv[n]  = ($urandom_range(0, 99) < 4);
        csr[n] = ($urandom_range(0, 99) < 4);
        brn[n] = ($urandom_range(0, 99) < 15);
        vec[n] = ($urandom_range(0, 99) < 15);
        rdv[n] = ($urandom_range(0, 99) < 70);
        inv[n] = ($urandom_range(0, 99) < 3);
        flt[n] = ($urandom_range(0, 99) < 3);
      end
      stall = ($urandom_range(0, 99) < 10);
      brq   = ($urandom_range(0, 99) < 5);
      ddone = ($urandom_range(0, 99) < 20);
      vdone = ($urandom_range(0, 99) < 25);
      rst   = ($urandom_range(0, 199) < 2);
      step("random");
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending got=%0d want=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
